// File: rtl/pulse_train_pkg.sv
// ----------------------------------------------------------------------------
// pulse_train_pkg
// Shared definitions for the pulse train generator: the FSM state encoding
// used by pulse_train_gen.
// ----------------------------------------------------------------------------
package pulse_train_pkg;

  // Width of the FSM state register.
  localparam int STATE_W = 2;

  // IDLE : waiting for a command, cmd_ready_o high
  // EMIT : presenting a beat, beat_valid_o high
  // GAP  : enforcing idle cycles between accepted beats
  // DONE : one-cycle completion / abort strobe
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : pulse_train_pkg

// File: rtl/pulse_gap_timer.sv
// ----------------------------------------------------------------------------
// pulse_gap_timer
// Loadable down-counter that times the idle cycles between beats.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset, clears the count
//   load       load load_value into the counter (wins over en)
//   en         decrement by one per cycle while the count is non-zero
//   load_value value to load
//   expire     count == 1: the last idle cycle is in progress
//   is_zero    count == 0: timer not running
// ----------------------------------------------------------------------------
module pulse_gap_timer #(
  parameter int WIDTH_P = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [WIDTH_P-1:0] load_value,
  output logic               expire,
  output logic               is_zero
);

  logic [WIDTH_P-1:0] count;

  // NOTE: sequential state is only ever assigned with <= so every register
  // samples its inputs at the same edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      // Saturate at zero so a stray enable never wraps to the maximum gap.
      count <= count - WIDTH_P'(1);
    end
  end

  assign expire  = (count == WIDTH_P'(1));
  assign is_zero = (count == '0);

endmodule : pulse_gap_timer

// File: rtl/pulse_train_gen.sv
// ----------------------------------------------------------------------------
// pulse_train_gen
// Turns a programmed count back into events: accepts {count N, gap G} on a
// valid/ready command port and emits exactly N single-beat events on a
// valid/ready output with G idle cycles after every accepted beat (except the
// last), then strobes done_o for one cycle. abort_i ends a burst early.
// All outputs are decoded from registered state only.
//
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   cmd_valid_i     command valid
//   cmd_ready_o     command accepted when valid & ready (high only in IDLE)
//   cmd_count_i     number of beats N (0 gives a done strobe with no beats)
//   cmd_gap_i       idle cycles G between accepted beats
//   abort_i         terminate the current burst (EMIT/GAP only)
//   beat_valid_o    beat valid, held until accepted
//   beat_ready_i    downstream accepts beat
//   beat_idx_o      0-based index of the current beat
//   beat_last_o     current beat is the final one
//   remaining_o     beats not yet accepted (held after abort)
//   busy_o          high in EMIT, GAP and DONE
//   done_o          one-cycle completion / abort strobe
// ----------------------------------------------------------------------------
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int WIDTH_P     = 16,
  parameter int GAP_WIDTH_P = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [WIDTH_P-1:0]     cmd_count_i,
  input  logic [GAP_WIDTH_P-1:0] cmd_gap_i,
  input  logic                   abort_i,
  output logic                   beat_valid_o,
  input  logic                   beat_ready_i,
  output logic [WIDTH_P-1:0]     beat_idx_o,
  output logic                   beat_last_o,
  output logic [WIDTH_P-1:0]     remaining_o,
  output logic                   busy_o,
  output logic                   done_o
);

  state_e                 state_q, state_d;
  logic [WIDTH_P-1:0]     remaining_q, remaining_d;
  logic [WIDTH_P-1:0]     idx_q, idx_d;
  logic [GAP_WIDTH_P-1:0] gap_q, gap_d;

  logic timer_load;
  logic timer_en;
  logic timer_expire;
  logic timer_zero;
  logic last_beat;

  assign last_beat = (remaining_q == WIDTH_P'(1));

  pulse_gap_timer #(
    .WIDTH_P (GAP_WIDTH_P)
  ) u_gap_timer (
    .clk        (clk_i),
    .rst_n      (rstn_i),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (gap_q),
    .expire     (timer_expire),
    .is_zero    (timer_zero)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d     = state_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    timer_load  = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // abort_i is ignored here, so a coincident command is still taken.
        if (cmd_valid_i) begin
          remaining_d = cmd_count_i;
          idx_d       = '0;
          gap_d       = cmd_gap_i;
          state_d     = (cmd_count_i == '0) ? ST_DONE : ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (beat_ready_i) begin
          // EMIT is only entered with remaining >= 1, so this never underflows.
          remaining_d = remaining_q - WIDTH_P'(1);
          // idx stops at N-1 so it never wraps, even for N = 2^WIDTH_P-1.
          if (!last_beat) begin
            idx_d = idx_q + WIDTH_P'(1);
          end
          // A beat accepted together with abort still counts.
          if (last_beat || abort_i) begin
            state_d = ST_DONE;
          end else if (gap_q == '0) begin
            state_d = ST_EMIT;
          end else begin
            timer_load = 1'b1;
            state_d    = ST_GAP;
          end
        end else if (abort_i) begin
          state_d = ST_DONE;
        end
      end

      ST_GAP: begin
        // Timer holds G on entry and counts down to 1, giving exactly G
        // idle cycles. The is_zero term only guards against a stuck GAP.
        timer_en = 1'b1;
        if (abort_i) begin
          state_d = ST_DONE;
        end else if (timer_expire || timer_zero) begin
          state_d = ST_EMIT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign beat_valid_o = (state_q == ST_EMIT);
  assign beat_last_o  = (state_q == ST_EMIT) && last_beat;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign beat_idx_o   = idx_q;
  assign remaining_o  = remaining_q;

endmodule : pulse_train_gen

// File: tb/tb_pulse_train_gen.sv
// ----------------------------------------------------------------------------
// tb_pulse_train_gen
// Directed, self-checking bench for pulse_train_gen. A table of
// {N, G, expected done cycle, expected beat count} records drives the
// free-running bursts; hand-written sequences cover stalls, aborts,
// zero-length commands, asynchronous reset and a narrow-width instance.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_pulse_train_gen;

  localparam int W  = 16;
  localparam int GW = 8;
  localparam int W4 = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rstn_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [W-1:0]  cmd_count_i;
  logic [GW-1:0] cmd_gap_i;
  logic          abort_i;
  logic          beat_valid_o;
  logic          beat_ready_i;
  logic [W-1:0]  beat_idx_o;
  logic          beat_last_o;
  logic [W-1:0]  remaining_o;
  logic          busy_o;
  logic          done_o;

  // Narrow instance for the no-wrap check at N = 2^W4-1.
  logic          cmd_valid4;
  logic          cmd_ready4;
  logic [W4-1:0] cmd_count4;
  logic [GW-1:0] cmd_gap4;
  logic          abort4;
  logic          beat_valid4;
  logic          beat_ready4;
  logic [W4-1:0] beat_idx4;
  logic          beat_last4;
  logic [W4-1:0] remaining4;
  logic          busy4;
  logic          done4;

  pulse_train_gen #(.WIDTH_P(W), .GAP_WIDTH_P(GW)) u_dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_count_i  (cmd_count_i),
    .cmd_gap_i    (cmd_gap_i),
    .abort_i      (abort_i),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_idx_o   (beat_idx_o),
    .beat_last_o  (beat_last_o),
    .remaining_o  (remaining_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  pulse_train_gen #(.WIDTH_P(W4), .GAP_WIDTH_P(GW)) u_dut4 (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .cmd_valid_i  (cmd_valid4),
    .cmd_ready_o  (cmd_ready4),
    .cmd_count_i  (cmd_count4),
    .cmd_gap_i    (cmd_gap4),
    .abort_i      (abort4),
    .beat_valid_o (beat_valid4),
    .beat_ready_i (beat_ready4),
    .beat_idx_o   (beat_idx4),
    .beat_last_o  (beat_last4),
    .remaining_o  (remaining4),
    .busy_o       (busy4),
    .done_o       (done4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 50 && !cmd_ready_o; i++) step();
    check(name, 32'(cmd_ready_o), 32'd1);
  endtask

  task automatic send_cmd(input int n, input int g);
    cmd_valid_i = 1'b1;
    cmd_count_i = W'(n);
    cmd_gap_i   = GW'(g);
    step();
    cmd_valid_i = 1'b0;
  endtask

  typedef struct {
    int count;
    int gap;
    int exp_done;   // cycles from accept edge to the done_o cycle
    int exp_beats;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int   beats, done_at, perr, hs, stall, dcnt, k;
    bit   stalled;
    logic exp_v;

    // done at cycle 1 + N + (N-1)*G when beat_ready_i stays high
    vecs[0] = '{count: 4, gap: 0,   exp_done: 5,   exp_beats: 4};
    vecs[1] = '{count: 3, gap: 2,   exp_done: 8,   exp_beats: 3};
    vecs[2] = '{count: 1, gap: 5,   exp_done: 2,   exp_beats: 1};
    vecs[3] = '{count: 0, gap: 7,   exp_done: 1,   exp_beats: 0};
    vecs[4] = '{count: 2, gap: 255, exp_done: 258, exp_beats: 2};
    vecs[5] = '{count: 6, gap: 1,   exp_done: 12,  exp_beats: 6};

    rstn_i       = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_count_i  = '0;
    cmd_gap_i    = '0;
    abort_i      = 1'b0;
    beat_ready_i = 1'b0;
    cmd_valid4   = 1'b0;
    cmd_count4   = '0;
    cmd_gap4     = '0;
    abort4       = 1'b0;
    beat_ready4  = 1'b0;

    // ---------------- reset state ----------------
    step();
    step();
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_valid",     32'(beat_valid_o), 32'd0);
    check("rst_done",      32'(done_o), 32'd0);
    check("rst_busy",      32'(busy_o), 32'd0);
    check("rst_remaining", 32'(remaining_o), 32'd0);
    check("rst_idx",       32'(beat_idx_o), 32'd0);
    rstn_i = 1'b1;
    step();

    // ---------------- table-driven bursts ----------------
    for (int v = 0; v < 6; v++) begin
      wait_ready("tbl_ready");
      beat_ready_i = 1'b1;
      send_cmd(vecs[v].count, vecs[v].gap);
      beats = 0; done_at = 0; perr = 0;
      for (int c = 1; c <= 400; c++) begin
        exp_v = (vecs[v].count > 0) &&
                (((c - 1) % (vecs[v].gap + 1)) == 0) &&
                (((c - 1) / (vecs[v].gap + 1)) < vecs[v].count);
        if (beat_valid_o !== exp_v) perr++;
        if (beat_valid_o === 1'b1) begin
          if (beat_idx_o !== W'(beats)) perr++;
          if (beat_last_o !== (beats == vecs[v].count - 1)) perr++;
          if (remaining_o !== W'(vecs[v].count - beats)) perr++;
          beats++;
        end
        if (done_o === 1'b1) begin
          done_at = c;
          check("tbl_ready_in_done", 32'(cmd_ready_o), 32'd0);
          break;
        end
        step();
      end
      check("tbl_done_cycle", 32'(done_at), 32'(vecs[v].exp_done));
      check("tbl_beats",      32'(beats), 32'(vecs[v].exp_beats));
      check("tbl_pattern_errs", 32'(perr), 32'd0);
      check("tbl_remaining_end", 32'(remaining_o), 32'd0);
      step();
      check("tbl_done_one_cycle", 32'(done_o), 32'd0);
      check("tbl_ready_after",    32'(cmd_ready_o), 32'd1);
    end

    // ---------------- stall: N=5 G=1, 3 stalled cycles on idx 2 ----------------
    wait_ready("stall_ready");
    send_cmd(5, 1);
    hs = 0; stall = 0; stalled = 1'b0; done_at = 0;
    for (int c = 0; c < 100; c++) begin
      if (done_o === 1'b1) begin done_at = 1; break; end
      if (beat_valid_o && beat_idx_o == W'(2) && !stalled) begin
        stalled = 1'b1;
        stall   = 3;
      end
      if (stall > 0) begin
        beat_ready_i = 1'b0;
        check("stall_valid_held", 32'(beat_valid_o), 32'd1);
        check("stall_idx",        32'(beat_idx_o), 32'd2);
        check("stall_remaining",  32'(remaining_o), 32'd3);
        stall--;
      end else begin
        beat_ready_i = 1'b1;
      end
      if (beat_valid_o && beat_ready_i) hs++;
      step();
    end
    check("stall_done_seen", 32'(done_at), 32'd1);
    check("stall_handshakes", 32'(hs), 32'd5);
    beat_ready_i = 1'b1;

    // ---------------- abort during GAP after 4 beats ----------------
    wait_ready("abgap_ready");
    send_cmd(10, 3);
    hs = 0;
    for (int c = 0; c < 100 && hs < 4; c++) begin
      if (beat_valid_o && beat_ready_i) hs++;
      step();
    end
    check("abgap_in_gap",    32'(beat_valid_o), 32'd0);
    check("abgap_busy",      32'(busy_o), 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abgap_done",      32'(done_o), 32'd1);
    check("abgap_rem_done",  32'(remaining_o), 32'd6);
    step();
    check("abgap_done_clr",  32'(done_o), 32'd0);
    check("abgap_idle",      32'(busy_o), 32'd0);
    check("abgap_rem_idle",  32'(remaining_o), 32'd6);
    step();
    check("abgap_rem_hold",  32'(remaining_o), 32'd6);

    // ---------------- abort coincident with 4th handshake ----------------
    wait_ready("abhs_ready");
    send_cmd(10, 3);
    hs = 0;
    for (int c = 0; c < 100 && hs < 3; c++) begin
      if (beat_valid_o && beat_ready_i) hs++;
      step();
    end
    for (int c = 0; c < 20 && !beat_valid_o; c++) step();
    check("abhs_valid_before", 32'(beat_valid_o), 32'd1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abhs_done",     32'(done_o), 32'd1);
    check("abhs_rem_done", 32'(remaining_o), 32'd6);
    step();
    check("abhs_rem_idle", 32'(remaining_o), 32'd6);
    check("abhs_idle",     32'(busy_o), 32'd0);

    // ---------------- abort in IDLE ignored / with command accepted ----------------
    abort_i = 1'b1;
    step();
    check("abidle_busy", 32'(busy_o), 32'd0);
    check("abidle_rem",  32'(remaining_o), 32'd6);
    send_cmd(2, 0);
    abort_i = 1'b0;
    check("abcmd_valid", 32'(beat_valid_o), 32'd1);
    check("abcmd_rem",   32'(remaining_o), 32'd2);
    for (int c = 0; c < 20 && !done_o; c++) step();
    check("abcmd_done",  32'(done_o), 32'd1);
    check("abcmd_rem_end", 32'(remaining_o), 32'd0);

    // ---------------- zero-length commands back to back ----------------
    wait_ready("zero_ready");
    cmd_valid_i = 1'b1;
    cmd_count_i = '0;
    cmd_gap_i   = GW'(4);
    step();
    check("zero_done1",  32'(done_o), 32'd1);
    check("zero_nrdy1",  32'(cmd_ready_o), 32'd0);
    check("zero_nvalid", 32'(beat_valid_o), 32'd0);
    step();
    check("zero_gap_done", 32'(done_o), 32'd0);
    check("zero_rdy",      32'(cmd_ready_o), 32'd1);
    step();
    check("zero_done2",  32'(done_o), 32'd1);
    cmd_valid_i = 1'b0;
    step();
    check("zero_done_clr", 32'(done_o), 32'd0);

    // ---------------- async reset mid-EMIT ----------------
    wait_ready("arst_ready");
    beat_ready_i = 1'b1;
    send_cmd(8, 0);
    hs = 0;
    for (int c = 0; c < 50 && hs < 3; c++) begin
      if (beat_valid_o && beat_ready_i) hs++;
      step();
    end
    check("arst_pre_valid", 32'(beat_valid_o), 32'd1);
    check("arst_pre_idx",   32'(beat_idx_o), 32'd3);
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_valid_drop", 32'(beat_valid_o), 32'd0);
    check("arst_busy",       32'(busy_o), 32'd0);
    check("arst_done",       32'(done_o), 32'd0);
    step();
    step();
    rstn_i = 1'b1;
    check("arst_ready_after", 32'(cmd_ready_o), 32'd1);
    check("arst_rem_after",   32'(remaining_o), 32'd0);
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done_o === 1'b1) dcnt++;
      step();
    end
    check("arst_no_done", 32'(dcnt), 32'd0);

    // ---------------- WIDTH_P=4, N=15: no wrap ----------------
    beat_ready4 = 1'b1;
    cmd_valid4  = 1'b1;
    cmd_count4  = 4'd15;
    cmd_gap4    = '0;
    step();
    cmd_valid4 = 1'b0;
    k = 0; done_at = 0;
    for (int c = 0; c < 40; c++) begin
      if (done4 === 1'b1) begin done_at = 1; break; end
      if (beat_valid4 === 1'b1) begin
        check("n4_idx",  32'(beat_idx4), 32'(k));
        check("n4_last", 32'(beat_last4), 32'(k == 14));
        k++;
      end
      step();
    end
    check("n4_done",      32'(done_at), 32'd1);
    check("n4_beats",     32'(k), 32'd15);
    check("n4_idx_final", 32'(beat_idx4), 32'd14);
    check("n4_rem_final", 32'(remaining4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pulse_train_gen

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Inverse of the event counter: it turns a count back into events rather than counting them.
- Accepts a command {count N, gap G} over a valid/ready handshake.
- Emits exactly N single-beat events on a valid/ready output, with G idle cycles enforced between accepted beats, then pulses done.
- Used in the Sobel pipeline to generate line/frame pixel strobes and padding beats from programmed lengths.

Parameters:
WIDTH_P, 16, width of burst count, remaining and index outputs
GAP_WIDTH_P, 8, width of inter-beat gap value

Ports:
clk_i  input  1  clock
rstn_i  input  1  reset, asynchronous, active-low
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&ready
cmd_count_i  input  WIDTH_P  number of beats N
cmd_gap_i  input  GAP_WIDTH_P  idle cycles G between beats
abort_i  input  1  terminate current burst
beat_valid_o  output  1  event beat valid
beat_ready_i  input  1  downstream accepts beat
beat_idx_o  output  WIDTH_P  0-based index of current beat
beat_last_o  output  1  current beat is final (remaining==1)
remaining_o  output  WIDTH_P  beats not yet accepted
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle completion/abort strobe

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rstn_i). Asserting rstn_i low immediately forces:
  - state = IDLE
  - remaining, idx, gap_cnt, latched gap = 0
  - beat_valid_o = 0, done_o = 0, busy_o = 0
- After reset, cmd_ready_o = 1.
- Reset mid-burst discards the burst; no done_o is generated.
- Outputs are decoded from registered state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i with N == 0: go to DONE (zero-length burst still produces done_o).
  - Otherwise: latch remaining = N, idx = 0, gap = G, then go to EMIT.
  - First beat_valid_o is asserted the cycle after acceptance (latency 1).
- EMIT:
  - beat_valid_o = 1. beat_valid_o holds until accepted and beat_idx_o is stable while stalled.
  - On beat_ready_i:
    - remaining -= 1, idx += 1
    - If remaining was 1: go to DONE.
    - Else if gap == 0: stay in EMIT (back-to-back beats every cycle).
    - Else: gap_cnt = gap, go to GAP.
- GAP:
  - beat_valid_o = 0.
  - gap_cnt decrements each cycle; when gap_cnt == 1, go to EMIT.
  - Result: exactly G cycles with beat_valid_o low between a handshake and the next valid.
- DONE:
  - done_o = 1 for exactly one cycle, cmd_ready_o = 0, then go to IDLE.
  - Minimum command-to-command spacing is therefore N beats + gaps + 2 cycles.
- abort_i:
  - In EMIT or GAP: go to DONE next cycle.
  - remaining_o holds the count of unsent beats through DONE and IDLE, until the next command.
  - abort_i coincident with an EMIT handshake: the beat counts (remaining decrements), then DONE.
  - abort_i in IDLE or DONE is ignored.
  - abort_i concurrent with cmd_valid_i in IDLE: the command is accepted.
- Width rules:
  - remaining and idx are WIDTH_P bits with no wrap: idx maxes at N-1 and remaining never underflows.
  - N = 2^WIDTH_P-1 must work.
  - gap is unsigned; G = 2^GAP_WIDTH_P-1 must work.
- beat_last_o = (state == EMIT) && (remaining == 1).
- busy_o is high in EMIT, GAP and DONE.

Decomposition:
- Package pulse_train_pkg:
  - state_e typedef (IDLE, EMIT, GAP, DONE) as a 2-bit enum
  - localparam for state encoding width
- One sub-module, pulse_gap_timer:
  - loadable GAP_WIDTH_P down-counter
  - inputs load/en; outputs expire when count==1 and is_zero
  - asynchronous active-low reset
- The top level holds the FSM and the remaining/idx registers.

Test Plan:
- N=4, G=0, beat_ready_i=1 → beat_valid_o high 4 consecutive cycles starting 1 cycle after accept; idx 0,1,2,3; last on idx 3; done_o 1 cycle later; cmd_ready_o low that cycle.
- N=3, G=2, ready=1 → valid pattern 1,0,0,1,0,0,1 then done_o; remaining 3→2→1→0.
- N=5, G=1, beat_ready_i low 3 cycles on beat idx 2 → valid held, idx stays 2, no count change; total 5 handshakes exactly.
- N=10, abort_i during GAP after 4 beats → done_o next cycle; remaining_o=6 held in IDLE. Repeat with abort coincident with the 4th handshake → remaining_o=6.
- N=0 command → no beat_valid_o; done_o exactly one cycle after accept; back-to-back cmd_valid_i accepted again after DONE.
- Reset asserted asynchronously mid-EMIT (N=8, after 3 beats) → beat_valid_o drops immediately without a clock edge, no done_o; after release cmd_ready_o=1 and remaining_o=0; WIDTH_P=4 run with N=15 gives idx 0..14 and no wrap.
